// File: rtl/tail_light_monitor.sv
// Receive-side checker for the Thunderbird tail-light sequencer: decodes each
// side's step, counts completed sweeps and latches the first protocol error.
module tail_light_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr_err,
    input  logic [2:0]       left_lamps,
    input  logic [2:0]       right_lamps,
    output logic [1:0]       left_step,
    output logic [1:0]       right_step,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count,
    output logic             sweep_done,
    output logic             err,
    output logic [2:0]       err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    typedef struct packed {
        state_t     nxt;
        logic [2:0] code;
        logic       done;
    } eval_t;

    state_t           r_left_st;
    state_t           r_right_st;
    logic [1:0]       r_dir;
    logic [CNT_W-1:0] r_left_cnt;
    logic [CNT_W-1:0] r_right_cnt;
    logic             r_sweep_done;
    logic             r_err;
    logic [2:0]       r_err_code;

    eval_t      w_left_ev;
    eval_t      w_right_ev;
    logic       w_conflict;
    logic [2:0] w_new_code;

    // Each legal pattern names exactly one state; anything unexpected
    // resyncs to that state, except a repeat of the current one (stall).
    function automatic eval_t side_eval(input state_t s, input logic [2:0] p);
        eval_t r;
        r.nxt  = s;
        r.code = 3'd0;
        r.done = 1'b0;
        case (p)
            3'b000: begin
                r.nxt  = IDLE;
                r.done = (s == S3);
            end
            3'b001: begin
                if (s == IDLE)    r.nxt = S1;
                else if (s == S1) r.code = 3'd3;
                else begin
                    r.code = 3'd2;
                    r.nxt  = S1;
                end
            end
            3'b011: begin
                if (s == S1)      r.nxt = S2;
                else if (s == S2) r.code = 3'd3;
                else begin
                    r.code = 3'd2;
                    r.nxt  = S2;
                end
            end
            3'b111: begin
                if (s == S2)      r.nxt = S3;
                else if (s == S3) r.code = 3'd3;
                else begin
                    r.code = 3'd2;
                    r.nxt  = S3;
                end
            end
            default: begin
                r.code = 3'd1;
                r.nxt  = IDLE;
            end
        endcase
        return r;
    endfunction

    always_comb begin
        w_left_ev  = side_eval(r_left_st, left_lamps);
        w_right_ev = side_eval(r_right_st, right_lamps);
        w_conflict = (|left_lamps) && (|right_lamps);
        w_new_code = 3'd0;
        if (w_left_ev.code == 3'd1 || w_right_ev.code == 3'd1)      w_new_code = 3'd1;
        else if (w_conflict)                                        w_new_code = 3'd4;
        else if (w_left_ev.code == 3'd2 || w_right_ev.code == 3'd2) w_new_code = 3'd2;
        else if (w_left_ev.code == 3'd3 || w_right_ev.code == 3'd3) w_new_code = 3'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_left_st    <= IDLE;
            r_right_st   <= IDLE;
            r_dir        <= 2'b00;
            r_left_cnt   <= '0;
            r_right_cnt  <= '0;
            r_sweep_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 3'd0;
        end else begin
            r_sweep_done <= 1'b0;
            if (en) begin
                r_left_st    <= w_left_ev.nxt;
                r_right_st   <= w_right_ev.nxt;
                r_dir        <= {|left_lamps, |right_lamps};
                r_sweep_done <= w_left_ev.done | w_right_ev.done;
                if (w_left_ev.done)  r_left_cnt  <= r_left_cnt + 1'b1;
                if (w_right_ev.done) r_right_cnt <= r_right_cnt + 1'b1;
            end
            // A fresh error beats a simultaneous clear and re-arms the code.
            if (en && w_new_code != 3'd0) begin
                r_err <= 1'b1;
                if (!r_err || clr_err) r_err_code <= w_new_code;
            end else if (clr_err) begin
                r_err      <= 1'b0;
                r_err_code <= 3'd0;
            end
        end
    end

    assign left_step   = r_left_st;
    assign right_step  = r_right_st;
    assign dir         = r_dir;
    assign left_count  = r_left_cnt;
    assign right_count = r_right_cnt;
    assign sweep_done  = r_sweep_done;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule

// File: doc/tail_light_monitor.md
# tail_light_monitor

Receive-side checker for the Thunderbird tail-light sequencer. It samples the two 3-lamp outputs (left and right), decodes each side's sequence step and the turn direction, and counts completed sweeps per side. It also detects protocol violations: illegal patterns, skipped or stalled steps, and both sides active at once. It sits beside the light controllers on the board and drives status LEDs or a bench scoreboard.

## Interface
Parameters:
- CNT_W, default 8: width of each per-side completed-sweep counter.

Ports:
- clk  input  1  sampling clock; the same clock as the light controllers.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; lamps are evaluated only on clk edges where en=1.
- clr_err  input  1  synchronous clear of the sticky error and the error code.
- left_lamps  input  3  {a,b,c} of the left side; c is the innermost lamp.
- right_lamps  input  3  {a,b,c} of the right side.
- left_step  output  2  decoded left step: 0 idle, 1 C, 2 CB, 3 CBA.
- right_step  output  2  decoded right step, same encoding.
- dir  output  2  00 none, 01 right, 10 left, 11 conflict.
- left_count  output  CNT_W  completed left sweeps; wraps modulo 2^CNT_W.
- right_count  output  CNT_W  completed right sweeps; wraps modulo 2^CNT_W.
- sweep_done  output  1  one-cycle pulse when either side completes a sweep.
- err  output  1  sticky error flag.
- err_code  output  3  code of the first error since the last clear: 1 illegal pattern, 2 skip, 3 stall, 4 conflict.

## Operation
- Legal lamp patterns {a,b,c}: 000, 001, 011, 111. Every other pattern (010, 100, 101, 110) is illegal.
- Each side has its own 4-state FSM: IDLE, S1, S2, S3. It updates only when en=1.
  - IDLE: 000 stays in IDLE; 001 moves to S1.
  - S1: 011 moves to S2.
  - S2: 111 moves to S3.
  - S3: 000 moves to IDLE, increments that side's count, and pulses sweep_done.
  - S1 or S2 seeing 000 is an abort: go to IDLE, no error, no count.
- Stall: a non-IDLE state sees the same pattern again. This is error 3. The FSM holds its state.
- Skip: any other legal-but-unexpected pattern (for example IDLE→011 or S1→111). This is error 2. The FSM resyncs to the state matching the pattern (000→IDLE, 001→S1, 011→S2, 111→S3).
- Illegal pattern: error 1. The FSM goes to IDLE.
- Conflict: both sampled patterns are nonzero. This is error 4. dir=11, and both FSMs still evaluate.
- dir: 10 if only the left pattern is nonzero, 01 if only the right, 00 if both are 000.
- Several errors in one sample: the highest-priority one is recorded. Priority is 1 > 4 > 2 > 3.
- err_code keeps the first error since the last clear; later errors set err but do not overwrite the code.
- clr_err and a new error in the same cycle: the new error wins, so err=1 and err_code is the new code.
- Both sides completing in the same sample: both counts increment, and sweep_done is a single pulse.

## Timing
- All outputs are registered. A sample taken at edge N shows on the outputs after edge N; latency is one cycle.
- With en=0 all state, counts, and dir hold, and sweep_done is 0.
- Reset values: left_step=0, right_step=0, dir=00, left_count=0, right_count=0, sweep_done=0, err=0, err_code=0. Both FSMs start in IDLE.
- Reset asserted mid-sweep clears everything immediately and asynchronously.
- After reset is released, the first sample is judged from IDLE. A sample of 011 is therefore a skip (error 2).
- A count at 2^CNT_W−1 wraps to 0 on the next completion; there is no error for wrap.

## Test plan
- Left sweep, en=1 every cycle: 000,001,011,111,000 → left_step 0,1,2,3,0; left_count=1; sweep_done high for one cycle; dir=10 during steps 1–3; err=0.
- Right sequence 001,001 → stall: err=1, err_code=3, right_step stays 1. Then clr_err=1 for one cycle → err=0, err_code=0.
- Left 001 then 111 → skip: err_code=2, left_step=3. A following 000 completes the sweep and left_count increments.
- Left 010 → err_code=1, left_step=0. In the same cycle right=001 → conflict is also present, and code 1 still wins by priority.
- Left=001 and right=001 together → dir=11, err_code=4, both steps=1. Then abort both with 000 → steps=0, no count change.
- CNT_W=2, four right sweeps → right_count 1,2,3,0. Assert reset during the fifth sweep at S2 → all outputs 0 immediately.
